// File: rtl/tx_pkg.sv
// tx_pkg
// Shared definitions for the transmit symbol path: scheduler FSM states,
// the number of 2-bit symbols in one 128-bit block, and the default
// symbol period in clock cycles.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SENDING,
    DRAIN
  } state_t;

  localparam int SYMS_PER_BLOCK      = 64;
  localparam int CLK_PER_SYM_DEFAULT = 100;

endpackage

// File: rtl/sym_tick_gen.sv
// sym_tick_gen
// Symbol period counter. Counts enabled cycles modulo CLK_PER_SYM and
// flags the last cycle of each symbol period.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-low reset
//   clr   - restart the period from zero (takes priority over en)
//   en    - count this cycle
//   tick  - high in the final enabled cycle of a symbol period
module sym_tick_gen
  import tx_pkg::*;
#(
  parameter int CLK_PER_SYM = CLK_PER_SYM_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_PER_SYM);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_SYM - 1);

  logic [CW-1:0] cnt;

  // Period counter: cleared on a block load so the first symbol gets a full
  // period, then advances only while a symbol is actually being presented.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/tx_symbol_scheduler.sv
// tx_symbol_scheduler
// Pulls 128-bit cipher blocks from upstream and hands them one at a time to
// a symbol serializer, pacing symbol advances at CLK_PER_SYM cycles each.
// Ports:
//   clk, reset            - clock and synchronous active-low reset
//   start, num_blocks     - frame request and its length in blocks
//   abort                 - stop the frame after the current block
//   in_data/in_valid/in_ready - upstream block handshake
//   cipher_data, load_en  - block and load strobe to the serializer
//   buffer_ready          - serializer idle and loadable
//   symbol_valid          - serializer presenting a symbol
//   mod_req               - symbol-advance strobe to the serializer
//   busy, done, underrun  - frame status
module tx_symbol_scheduler
  import tx_pkg::*;
#(
  parameter int CLK_PER_SYM = CLK_PER_SYM_DEFAULT,
  parameter int BLK_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             abort,
  input  logic [127:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [127:0]     cipher_data,
  output logic             load_en,
  input  logic             buffer_ready,
  input  logic             symbol_valid,
  output logic             mod_req,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  state_t           state;
  logic [BLK_W-1:0] blk_left;
  logic             abort_pend;
  logic             first_send;
  logic             sym_en;

  // Symbol pacing only runs while a block is on the wire, so a reset or an
  // idle serializer that still shows symbol_valid cannot produce mod_req.
  assign sym_en   = (state == SENDING) && symbol_valid;
  assign in_ready = (state == FETCH) && buffer_ready;

  sym_tick_gen #(
    .CLK_PER_SYM(CLK_PER_SYM)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (load_en),
    .en   (sym_en),
    .tick (mod_req)
  );

  // Frame sequencer. load_en and done are single-cycle pulses defaulted low
  // every cycle. The serializer needs one cycle after load_en to drop
  // buffer_ready, so the end-of-block test is masked for that first cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cipher_data <= '0;
      blk_left    <= '0;
      abort_pend  <= 1'b0;
      first_send  <= 1'b0;
      load_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      load_en <= 1'b0;
      done    <= 1'b0;
      if (state != IDLE && abort) abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            blk_left   <= num_blocks;
            underrun   <= 1'b0;
            abort_pend <= 1'b0;
            if (num_blocks == '0) begin
              done <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end

        FETCH: begin
          // Abort beats a simultaneous handshake: the block is not taken.
          if (abort) begin
            state <= DRAIN;
          end else if (in_valid && buffer_ready) begin
            cipher_data <= in_data;
            load_en     <= 1'b1;
            state       <= LOAD;
          end else if (buffer_ready && blk_left != '0) begin
            underrun <= 1'b1;
          end
        end

        LOAD: begin
          blk_left   <= blk_left - BLK_W'(1);
          first_send <= 1'b1;
          state      <= SENDING;
        end

        SENDING: begin
          first_send <= 1'b0;
          if (!first_send && buffer_ready && !symbol_valid) begin
            if (blk_left != '0 && !abort_pend && !abort) begin
              state <= FETCH;
            end else begin
              done       <= 1'b1;
              busy       <= 1'b0;
              abort_pend <= 1'b0;
              state      <= IDLE;
            end
          end
        end

        DRAIN: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// tb_tx_symbol_scheduler
// Scoreboard bench for tx_symbol_scheduler with a behavioural symbol
// serializer (MSB-first, 2-bit symbols, 64 per block) and an upstream block
// source. Expected load/symbol/done events are queued as stimulus is issued
// and consumed by a monitor whenever the DUT strobes an output.
module tb_tx_symbol_scheduler;
  import tx_pkg::*;

  localparam int CPS = 10;
  localparam int BW  = 5;
  localparam logic [1:0] EV_LOAD = 2'd0;
  localparam logic [1:0] EV_SYM  = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;

  typedef struct {
    logic [1:0]   kind;
    logic [127:0] data;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [BW-1:0] num_blocks;
  logic [127:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  cipher_data;
  logic          load_en;
  logic          buffer_ready;
  logic          symbol_valid;
  logic          mod_req;
  logic          busy;
  logic          done;
  logic          underrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_load = 0;
  int n_mod  = 0;
  int n_done = 0;
  int last_evt = 0;
  sb_entry_t  sb_q[$];
  logic [1:0] cap_syms[$];

  logic [127:0] up_blocks [32];
  int           up_idx   = 0;
  int           up_count = 0;

  logic         ser_flush;
  logic [127:0] ser_shift = '0;
  int           ser_left  = 0;
  logic [1:0]   cur_sym;

  always #5 clk = ~clk;

  tx_symbol_scheduler #(
    .CLK_PER_SYM(CPS),
    .BLK_W      (BW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_blocks  (num_blocks),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cipher_data (cipher_data),
    .load_en     (load_en),
    .buffer_ready(buffer_ready),
    .symbol_valid(symbol_valid),
    .mod_req     (mod_req),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  // Upstream source: presents queued blocks in order; a block counts as
  // taken on a handshake cycle without abort.
  assign in_data  = up_blocks[up_idx[4:0]];
  assign in_valid = (up_idx < up_count);

  initial forever begin
    @(posedge clk);
    if (in_valid && in_ready && !abort) up_idx <= up_idx + 1;
  end

  // symbol_serializer model
  assign buffer_ready = (ser_left == 0);
  assign symbol_valid = (ser_left != 0);
  assign cur_sym      = ser_shift[127:126];

  initial forever begin
    @(posedge clk);
    if (ser_flush) begin
      ser_left <= 0;
    end else if (load_en) begin
      ser_shift <= cipher_data;
      ser_left  <= SYMS_PER_BLOCK;
    end else if (mod_req && ser_left != 0) begin
      ser_shift <= ser_shift << 2;
      ser_left  <= ser_left - 1;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectEvent(logic [1:0] kind, logic [127:0] act, string name);
    sb_entry_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got unexpected event kind %0d data %0h expected none", name, kind, act);
    end else begin
      e = sb_q.pop_front();
      if (e.kind !== kind || e.data !== act) begin
        errors++;
        $display("[TB] FAIL %s: got kind %0d data %0h expected kind %0d data %0h",
                 name, kind, act, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (load_en === 1'b1) begin
      n_load++;
      checkOutput("load_mod_exclusive", {127'b0, mod_req}, 128'd0);
      expectEvent(EV_LOAD, cipher_data, "load_block");
      last_evt = cyc;
    end
    if (mod_req === 1'b1) begin
      n_mod++;
      cap_syms.push_back(cur_sym);
      checkOutput("symbol_period", 128'(cyc - last_evt), 128'(CPS));
      last_evt = cyc;
      expectEvent(EV_SYM, {126'b0, cur_sym}, "symbol_value");
    end
    if (done === 1'b1) begin
      n_done++;
      expectEvent(EV_DONE, {126'b0, busy, underrun}, "frame_done");
    end
  end

  task automatic pushSyms(logic [127:0] d, int n);
    sb_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.kind = EV_SYM;
      e.data = {126'b0, d[127 - 2*i -: 2]};
      sb_q.push_back(e);
    end
  endtask

  task automatic pushBlock(logic [127:0] d);
    sb_entry_t e;
    e.kind = EV_LOAD;
    e.data = d;
    sb_q.push_back(e);
    pushSyms(d, SYMS_PER_BLOCK);
  endtask

  task automatic pushDone(logic und);
    sb_entry_t e;
    e.kind = EV_DONE;
    e.data = {126'b0, 1'b0, und};
    sb_q.push_back(e);
  endtask

  task automatic loadUp(logic [127:0] d);
    up_blocks[up_count[4:0]] = d;
    up_count++;
  endtask

  task automatic applyStimulus(int n);
    num_blocks = BW'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic waitIdle(string name, int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (sb_q.size() == 0 && busy === 1'b0) break;
    end
    checkOutput(name, 128'(sb_q.size()), 128'd0);
  endtask

  task automatic waitMods(int target, int max);
    for (int i = 0; i < max; i++) begin
      if (n_mod >= target) break;
      tick();
    end
    checkOutput("wait_mod_reached", {127'b0, n_mod >= target}, 128'd1);
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, "_load_en"},  {127'b0, load_en},  128'd0);
    checkOutput({tag, "_mod_req"},  {127'b0, mod_req},  128'd0);
    checkOutput({tag, "_in_ready"}, {127'b0, in_ready}, 128'd0);
    checkOutput({tag, "_busy"},     {127'b0, busy},     128'd0);
    checkOutput({tag, "_done"},     {127'b0, done},     128'd0);
    checkOutput({tag, "_underrun"}, {127'b0, underrun}, 128'd0);
    checkOutput({tag, "_cipher"},   cipher_data,        128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] d0, d1, d2;
    logic [1:0]   s;
    int           bl, bm, bd;
    int           exp6[6];
    exp6 = '{3, 0, 0, 0, 0, 3};

    reset = 1'b0; start = 1'b0; abort = 1'b0; num_blocks = '0; ser_flush = 1'b1;
    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b1;
    ser_flush = 1'b0;
    tick();

    $display("[TB] single block");
    d0 = 128'hC0300C03F00FAA55123456789ABCDEF0;
    bl = n_load; bm = n_mod; bd = n_done;
    loadUp(d0); pushBlock(d0); pushDone(1'b0);
    applyStimulus(1);
    waitIdle("single_drain", 1500);
    checkOutput("single_loads", 128'(n_load - bl), 128'd1);
    checkOutput("single_mods",  128'(n_mod - bm),  128'd64);
    checkOutput("single_dones", 128'(n_done - bd), 128'd1);
    checkOutput("single_busy",  {127'b0, busy},    128'd0);
    for (int i = 0; i < 6; i++) begin
      s = (i < cap_syms.size()) ? cap_syms[i] : 2'bxx;
      checkOutput("single_first_syms", {126'b0, s}, 128'(exp6[i]));
    end

    $display("[TB] three blocks back-to-back");
    d0 = 128'h0123456789ABCDEF0011223344556677;
    d1 = 128'hFFEEDDCCBBAA99887766554433221100;
    d2 = 128'h5A5AA5A50F0FF0F03C3CC3C396966969;
    bl = n_load; bm = n_mod; bd = n_done;
    loadUp(d0); loadUp(d1); loadUp(d2);
    pushBlock(d0); pushBlock(d1); pushBlock(d2); pushDone(1'b0);
    applyStimulus(3);
    waitIdle("three_drain", 2500);
    checkOutput("three_loads",    128'(n_load - bl), 128'd3);
    checkOutput("three_mods",     128'(n_mod - bm),  128'd192);
    checkOutput("three_dones",    128'(n_done - bd), 128'd1);
    checkOutput("three_underrun", {127'b0, underrun}, 128'd0);

    $display("[TB] late data");
    d0 = 128'h11111111222222223333333344444444;
    d1 = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;
    bl = n_load; bm = n_mod;
    loadUp(d0); pushBlock(d0); pushBlock(d1); pushDone(1'b1);
    applyStimulus(2);
    waitMods(bm + 64, 900);
    repeat (52) tick();
    loadUp(d1);
    waitIdle("late_drain", 1500);
    checkOutput("late_underrun", {127'b0, underrun}, 128'd1);
    checkOutput("late_loads",    128'(n_load - bl),  128'd2);
    checkOutput("late_mods",     128'(n_mod - bm),   128'd128);

    $display("[TB] abort during block 1 of 4");
    d0 = 128'hA0A0A0A0B1B1B1B1C2C2C2C2D3D3D3D3;
    bl = n_load; bm = n_mod; bd = n_done;
    loadUp(d0); loadUp(~d0); loadUp(d0 ^ 128'h1); loadUp(d0 ^ 128'h2);
    pushBlock(d0); pushDone(1'b0);
    applyStimulus(4);
    waitMods(bm + 5, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    waitIdle("abort_drain", 1500);
    checkOutput("abort_loads", 128'(n_load - bl), 128'd1);
    checkOutput("abort_mods",  128'(n_mod - bm),  128'd64);
    checkOutput("abort_dones", 128'(n_done - bd), 128'd1);
    up_count = up_idx;

    $display("[TB] abort in FETCH with simultaneous data");
    bl = n_load;
    pushDone(1'b1);
    applyStimulus(2);
    repeat (5) tick();
    loadUp(128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    waitIdle("fetch_abort_drain", 50);
    checkOutput("fetch_abort_loads",  128'(n_load - bl), 128'd0);
    checkOutput("fetch_abort_cipher", cipher_data, d0);
    up_count = up_idx;

    $display("[TB] zero-length frame");
    bl = n_load;
    pushDone(1'b0);
    applyStimulus(0);
    checkOutput("zero_done_next",  {127'b0, done}, 128'd1);
    tick();
    checkOutput("zero_done_pulse", {127'b0, done}, 128'd0);
    checkOutput("zero_loads",      128'(n_load - bl), 128'd0);
    waitIdle("zero_drain", 10);

    $display("[TB] reset mid-block");
    d0 = 128'h6B6B6B6B7C7C7C7C8D8D8D8D9E9E9E9E;
    bl = n_load; bm = n_mod;
    loadUp(d0);
    begin
      sb_entry_t e;
      e.kind = EV_LOAD;
      e.data = d0;
      sb_q.push_back(e);
    end
    pushSyms(d0, 20);
    applyStimulus(1);
    waitMods(bm + 20, 400);
    reset = 1'b0;
    tick();
    checkAllZero("midframe_reset");
    reset = 1'b1;
    repeat (100) tick();
    checkOutput("post_reset_mods",  128'(n_mod - bm),  128'd20);
    checkOutput("post_reset_loads", 128'(n_load - bl), 128'd1);
    checkOutput("post_reset_sb",    128'(sb_q.size()), 128'd0);
    ser_flush = 1'b1;
    tick();
    ser_flush = 1'b0;

    $display("[TB] recovery frame after reset");
    d0 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    bm = n_mod;
    loadUp(d0); pushBlock(d0); pushDone(1'b0);
    applyStimulus(1);
    waitIdle("recover_drain", 1500);
    checkOutput("recover_mods", 128'(n_mod - bm), 128'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_symbol_scheduler.md
TX_SYMBOL_SCHEDULER -- requirements
Module: tx_symbol_scheduler

Interface
REQ-001 Parameter CLK_PER_SYM, default 100, clk cycles per symbol (legal range 4..1023).
REQ-002 Parameter BLK_W, default 5, width of num_blocks (frames of up to 31 blocks).
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  single-cycle frame start request.
REQ-006 num_blocks  input  BLK_W  number of 128-bit blocks in the frame; sampled on an accepted start.
REQ-007 abort  input  1  requests the frame to stop after the block currently being sent.
REQ-008 in_data  input  128  upstream cipher block.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  scheduler accepts in_data this cycle.
REQ-011 cipher_data  output  128  block driven to the serializer.
REQ-012 load_en  output  1  one-cycle load strobe to the serializer.
REQ-013 buffer_ready  input  1  serializer is idle and loadable.
REQ-014 symbol_valid  input  1  serializer is presenting a symbol.
REQ-015 mod_req  output  1  one-cycle symbol-advance strobe to the serializer.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the frame ends normally or after an abort.
REQ-018 underrun  output  1  sticky flag: upstream data was late mid-frame.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, LOAD, SENDING and DRAIN.
REQ-020 IDLE: start=1 SHALL latch num_blocks into blk_left and clear underrun. If num_blocks=0 the FSM SHALL pulse done on the next cycle and stay in IDLE; otherwise it SHALL go to FETCH.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 FETCH: in_ready SHALL equal buffer_ready. On in_valid&in_ready the scheduler SHALL register in_data into cipher_data and go to LOAD.
REQ-023 LOAD: the scheduler SHALL assert load_en for exactly one cycle, decrement blk_left and go to SENDING. in_ready SHALL be 0.
REQ-024 The symbol counter SHALL be cleared on the load_en cycle, count while symbol_valid=1, and wrap at CLK_PER_SYM-1. mod_req SHALL be high in the wrap cycle only, and only when symbol_valid=1.
REQ-025 Consequence of REQ-024: each symbol, including the first (presented immediately after load), SHALL last exactly CLK_PER_SYM cycles. A block SHALL take 64*CLK_PER_SYM cycles.
REQ-026 SENDING: the FSM SHALL ignore buffer_ready during the first cycle after load_en. It SHALL leave SENDING when buffer_ready=1 and symbol_valid=0.
REQ-027 On leaving SENDING: if blk_left>0 and no abort is pending, the FSM SHALL go to FETCH; otherwise it SHALL pulse done and go to IDLE.
REQ-028 In FETCH, if blk_left>0 and in_valid=0 while buffer_ready=1, underrun SHALL set. The FSM SHALL keep waiting.
REQ-029 An abort SHALL be latched as pending in any state except IDLE.
REQ-030 abort in FETCH SHALL go to DRAIN without loading a block.
REQ-031 DRAIN SHALL pulse done and go to IDLE in the next cycle.
REQ-032 When abort and in_valid&in_ready occur in the same FETCH cycle, abort SHALL win and the data SHALL NOT be accepted.
REQ-033 mod_req and load_en SHALL never be asserted in the same cycle.

Reset
REQ-034 With reset=0 at a clock edge, state SHALL be IDLE and the following SHALL be 0: cipher_data, blk_left, symbol counter, abort pending, load_en, mod_req, in_ready, busy, done and underrun.
REQ-035 Reset mid-frame SHALL take effect on the next edge. No further load_en or mod_req SHALL be issued until the next start.

Structure
REQ-036 A shared package tx_pkg SHALL hold the FSM state enum, SYMS_PER_BLOCK=64 and the CLK_PER_SYM default.
REQ-037 The symbol tick counter SHALL be a sub-module named sym_tick_gen with ports clk, reset, clr, en, tick, parameterised by CLK_PER_SYM.

Verification
REQ-038 The bench SHALL instantiate the scheduler with symbol_serializer and CLK_PER_SYM=10. All scenarios below SHALL be covered.
REQ-039 Single block: start, num_blocks=1, in_data=128'hC0300C03F00FAA55123456789ABCDEF0 -> one load_en; symbols 3,0,0,0,0,3 captured; 64 mod_req pulses 10 cycles apart; one done pulse; busy low afterwards.
REQ-040 Three blocks back-to-back with in_valid always high -> exactly 3 load_en, 192 mod_req, 1 done, underrun=0.
REQ-041 Late data: num_blocks=2, in_valid for block 2 held low 50 cycles -> underrun=1, block 2 still sent, done asserted.
REQ-042 Abort during block 1 of 4 -> block 1 completes (64 mod_req), no second load_en, done pulse.
REQ-043 num_blocks=0 -> done one cycle after start, no load_en; reset at symbol 20 of a block -> all outputs 0 next cycle, no mod_req until a new start.
